// File: rtl/aes_block_streamer_if.sv
// Host byte streams and AES core handshake for aes_block_streamer, bundled so
// the streamer and its environment share one connection point.
interface aes_block_streamer_if;
   logic [7:0]   in_data_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic         dec_i;
   logic [7:0]   out_data_o;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         aes_load_o;
   logic         aes_dec_o;
   logic [127:0] aes_data_o;
   logic [127:0] aes_data_i;
   logic         aes_busy_i;
   logic         trig_o;
   logic         err_o;

   modport slave (
      input  in_data_i, in_valid_i, dec_i, out_ready_i, aes_data_i, aes_busy_i,
      output in_ready_o, out_data_o, out_valid_o, aes_load_o, aes_dec_o,
             aes_data_o, trig_o, err_o
   );

   modport master (
      output in_data_i, in_valid_i, dec_i, out_ready_i, aes_data_i, aes_busy_i,
      input  in_ready_o, out_data_o, out_valid_o, aes_load_o, aes_dec_o,
             aes_data_o, trig_o, err_o
   );
endinterface

// File: rtl/aes_block_streamer.sv
// Collects 16 host bytes into a 128-bit block, hands it to an AES core with a
// one-cycle load strobe, waits for the core to start and finish, then streams
// the 16 result bytes back to the host. Byte 0 is always the block MSB.
module aes_block_streamer #(
   parameter int START_TIMEOUT = 4
) (
   input logic                 clk,
   input logic                 rst,
   aes_block_streamer_if.slave bus
);

   typedef enum logic [2:0] {COLLECT, LOAD, WAIT_START, WAIT_DONE, EMIT} state_t;

   state_t       state;
   state_t       state_next;
   logic [3:0]   in_cnt;
   logic [3:0]   out_cnt;
   logic [15:0]  wait_cnt;
   logic [127:0] block_q;
   logic [127:0] result_q;
   logic         dec_q;
   logic         ready_q;
   logic         trig_q;
   logic         err_q;
   logic         in_fire;
   logic         out_fire;
   logic         timeout_hit;

   // Handshake qualifiers; wait_cnt counts cycles since LOAD, the LOAD cycle included
   always_comb begin
      in_fire     = (state == COLLECT) && ready_q && bus.in_valid_i;
      out_fire    = (state == EMIT) && bus.out_ready_i;
      timeout_hit = (state == WAIT_START) && !bus.aes_busy_i &&
                    (wait_cnt >= 16'(START_TIMEOUT - 1));
   end

   // Next-state selection; busy is only looked at once WAIT_START is reached
   always_comb begin
      state_next = state;
      case (state)
         COLLECT:    if (in_fire && in_cnt == 4'd15) state_next = LOAD;
         LOAD:       state_next = WAIT_START;
         WAIT_START: begin
            if (bus.aes_busy_i)   state_next = WAIT_DONE;
            else if (timeout_hit) state_next = COLLECT;
         end
         WAIT_DONE:  if (!bus.aes_busy_i) state_next = EMIT;
         EMIT:       if (out_fire && out_cnt == 4'd15) state_next = COLLECT;
         default:    state_next = COLLECT;
      endcase
   end

   // State register plus ready/trigger flags registered from the upcoming state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= COLLECT;
         ready_q <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         state   <= state_next;
         ready_q <= (state_next == COLLECT);
         trig_q  <= (state_next == LOAD) || (state_next == WAIT_START) ||
                    (state_next == WAIT_DONE);
      end
   end

   // Block assembly, start timeout, result capture and output byte pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt   <= 4'd0;
         out_cnt  <= 4'd0;
         wait_cnt <= 16'd0;
         block_q  <= 128'd0;
         result_q <= 128'd0;
         dec_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (in_fire) begin
            block_q[{~in_cnt, 3'b111} -: 8] <= bus.in_data_i;
            in_cnt <= in_cnt + 4'd1;
            if (in_cnt == 4'd0) begin
               dec_q <= bus.dec_i;
               err_q <= 1'b0;
            end
         end
         if (state == LOAD)
            wait_cnt <= 16'd1;
         else if (state == WAIT_START && !bus.aes_busy_i && !timeout_hit)
            wait_cnt <= wait_cnt + 16'd1;
         if (timeout_hit)
            err_q <= 1'b1;
         if (state == WAIT_DONE && !bus.aes_busy_i)
            result_q <= bus.aes_data_i;
         if (out_fire)
            out_cnt <= out_cnt + 4'd1;
      end
   end

   assign bus.in_ready_o  = ready_q;
   assign bus.out_valid_o = (state == EMIT);
   assign bus.out_data_o  = result_q[{~out_cnt, 3'b111} -: 8];
   assign bus.aes_load_o  = (state == LOAD);
   assign bus.aes_dec_o   = dec_q;
   assign bus.aes_data_o  = block_q;
   assign bus.trig_o      = trig_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_aes_block_streamer.sv
// Bench for aes_block_streamer: a table of blocks run through a simple AES core
// model (busy one cycle after load for 40 cycles, result = block ^ A5 pattern),
// plus hand-written start-timeout and mid-block reset sequences.
module tb_aes_block_streamer;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   aes_block_streamer_if bus ();

   aes_block_streamer #(.START_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock and cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: busy rises the cycle after load and is held 40 cycles
   int           busy_cnt;
   logic [127:0] core_data;
   bit           no_busy = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt  <= 0;
         core_data <= '0;
      end else if (bus.aes_load_o && !no_busy) begin
         busy_cnt  <= 40;
         core_data <= bus.aes_data_o ^ {16{8'hA5}};
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign bus.aes_busy_i = (busy_cnt != 0);
   assign bus.aes_data_i = core_data;

   // Observation of strobes, trigger width and busy-fall/valid-rise timing
   int load_cnt, load_cyc, trig_cnt, fall_cyc, first_valid_cyc, acc_cyc;
   bit busy_prev = 1'b0, valid_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.aes_load_o) begin
         load_cnt = load_cnt + 1;
         load_cyc = cyc;
      end
      if (bus.trig_o) trig_cnt = trig_cnt + 1;
      if (busy_prev && !bus.aes_busy_i) fall_cyc = cyc;
      if (bus.out_valid_o && !valid_prev) first_valid_cyc = cyc;
      busy_prev  = bus.aes_busy_i;
      valid_prev = bus.out_valid_o;
   end

   typedef struct {
      logic [127:0] blk;
      logic         dec0;
      bit           toggle;
      bit           gap;
      int           stall_k;
      int           stall_n;
      logic [127:0] exp_aes;
      logic         exp_dec;
      logic [127:0] exp_out;
   } vec_t;

   vec_t tbl[6];

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Offer one byte until it is accepted, optionally followed by an idle cycle
   task automatic apply_stimulus(input logic [7:0] b, input logic d, input bit gap);
      int budget = 0;
      bit rdy;
      bus.in_data_i  = b;
      bus.dec_i      = d;
      bus.in_valid_i = 1'b1;
      do begin
         rdy = bus.in_ready_o;
         @(posedge clk); #1;
         budget++;
      end while (!rdy && budget < 200);
      acc_cyc = cyc;
      bus.in_valid_i = 1'b0;
      check_output("in_accept", rdy, 1'b1);
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_block(input logic [127:0] blk, input logic dec0, input bit toggle, input bit gap);
      logic [7:0] b;
      logic       d;
      for (int k = 0; k < 16; k++) begin
         b = blk[127 - 8*k -: 8];
         d = (k == 0 || !toggle) ? dec0 : logic'(k % 2);
         apply_stimulus(b, d, gap);
      end
   endtask

   task automatic check_reset_values();
      check_output("rst_in_ready", bus.in_ready_o, 1'b0);
      check_output("rst_out_valid", bus.out_valid_o, 1'b0);
      check_output("rst_out_data", bus.out_data_o, 8'h00);
      check_output("rst_load", bus.aes_load_o, 1'b0);
      check_output("rst_dec", bus.aes_dec_o, 1'b0);
      check_output("rst_aes_data", bus.aes_data_o, 128'd0);
      check_output("rst_trig", bus.trig_o, 1'b0);
      check_output("rst_err", bus.err_o, 1'b0);
   endtask

   // Run one table entry end to end and compare against the model's expectations
   task automatic run_block(input vec_t r);
      logic [7:0] got[$];
      logic [7:0] held = 8'h00;
      int k = 0, budget = 0, stall_done = 0;
      load_cnt = 0;
      trig_cnt = 0;
      send_block(r.blk, r.dec0, r.toggle, r.gap);
      bus.out_ready_i = 1'b0;
      while (k < 16 && budget < 400) begin
         if (bus.out_valid_o) begin
            if (k == r.stall_k && stall_done < r.stall_n) begin
               if (stall_done == 0) held = bus.out_data_o;
               else check_output("hold_stable", bus.out_data_o, held);
               bus.out_ready_i = 1'b0;
               stall_done++;
            end else begin
               if (k == r.stall_k) check_output("hold_release", bus.out_data_o, held);
               got.push_back(bus.out_data_o);
               bus.out_ready_i = 1'b1;
               k++;
            end
         end else begin
            bus.out_ready_i = 1'b0;
         end
         @(posedge clk); #1;
         budget++;
      end
      bus.out_ready_i = 1'b0;
      check_output("out_count", k, 16);
      check_output("valid_drop", bus.out_valid_o, 1'b0);
      check_output("ready_back", bus.in_ready_o, 1'b1);
      for (int i = 0; i < got.size(); i++)
         check_output($sformatf("out_byte%0d", i), got[i], r.exp_out[127 - 8*i -: 8]);
      check_output("aes_data", bus.aes_data_o, r.exp_aes);
      check_output("aes_dec", bus.aes_dec_o, r.exp_dec);
      check_output("load_pulses", load_cnt, 1);
      check_output("load_cycle", load_cyc, acc_cyc);
      check_output("trig_cycles", trig_cnt, 42);
      check_output("valid_latency", first_valid_cyc, fall_cyc + 1);
      check_output("err_clear", bus.err_o, 1'b0);
   endtask

   initial begin
      vec_t fresh;
      bus.in_data_i   = 8'h00;
      bus.in_valid_i  = 1'b0;
      bus.dec_i       = 1'b0;
      bus.out_ready_i = 1'b0;
      load_cnt = 0; trig_cnt = 0; load_cyc = -1; fall_cyc = -1;
      first_valid_cyc = -1; acc_cyc = -2;

      tbl[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0, -1, 0,
                 128'h00112233445566778899aabbccddeeff, 1'b0,
                 128'hA5B48796E1F0C3D22D3C0F1E69784B5A};
      tbl[1] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1, 1'b0, -1, 0,
                 128'h00112233445566778899aabbccddeeff, 1'b1,
                 128'hA5B48796E1F0C3D22D3C0F1E69784B5A};
      tbl[2] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b1, 7, 3,
                 128'h00112233445566778899aabbccddeeff, 1'b0,
                 128'hA5B48796E1F0C3D22D3C0F1E69784B5A};
      for (int i = 3; i < 6; i++) begin
         tbl[i].blk     = {$urandom, $urandom, $urandom, $urandom};
         tbl[i].dec0    = logic'($urandom_range(0, 1));
         tbl[i].toggle  = 1'b1;
         tbl[i].gap     = bit'($urandom_range(0, 1));
         tbl[i].stall_k = int'($urandom_range(0, 15));
         tbl[i].stall_n = int'($urandom_range(1, 4));
         tbl[i].exp_aes = tbl[i].blk;
         tbl[i].exp_dec = tbl[i].dec0;
         tbl[i].exp_out = tbl[i].blk ^ {16{8'hA5}};
      end

      // Power-on reset
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_values();
      rst = 1'b0;
      @(posedge clk); #1;
      check_output("ready_after_reset", bus.in_ready_o, 1'b1);

      for (int i = 0; i < 6; i++) run_block(tbl[i]);

      // Start timeout: the core never reports busy
      no_busy = 1'b1;
      send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0);
      check_output("to_load", bus.aes_load_o, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         check_output("to_no_valid", bus.out_valid_o, 1'b0);
         if (i <= 3) begin
            check_output("to_err_low", bus.err_o, 1'b0);
            check_output("to_trig_high", bus.trig_o, 1'b1);
         end else begin
            check_output("to_err_set", bus.err_o, 1'b1);
            check_output("to_trig_low", bus.trig_o, 1'b0);
            check_output("to_ready", bus.in_ready_o, 1'b1);
         end
      end
      no_busy = 1'b0;
      apply_stimulus(8'h00, 1'b1, 1'b0);
      check_output("err_cleared_by_byte0", bus.err_o, 1'b0);
      check_output("dec_latched_byte0", bus.aes_dec_o, 1'b1);

      // Reset after byte 9 of a partial block discards it
      for (int k = 1; k <= 9; k++) apply_stimulus(8'(k * 17), 1'b0, 1'b0);
      rst = 1'b1;
      #2 check_reset_values();
      @(posedge clk); #1;
      rst = 1'b0;
      check_output("ready_low_before_edge", bus.in_ready_o, 1'b0);
      @(posedge clk); #1;
      check_output("ready_after_midreset", bus.in_ready_o, 1'b1);

      fresh.blk     = {$urandom, $urandom, $urandom, $urandom};
      fresh.dec0    = 1'b1;
      fresh.toggle  = 1'b1;
      fresh.gap     = 1'b0;
      fresh.stall_k = -1;
      fresh.stall_n = 0;
      fresh.exp_aes = fresh.blk;
      fresh.exp_dec = 1'b1;
      fresh.exp_out = fresh.blk ^ {16{8'hA5}};
      run_block(fresh);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
